// File: rtl/i2c_la_pkg.sv
// Shared definitions for the logic-analyzer I2C path (conditioner and decoder).
package i2c_la_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } bus_state_e;

   localparam int BIT_CNT_W = 4;
   localparam logic [BIT_CNT_W-1:0] ACK_IDX = 4'd8;

   // Bit index runs 0..7 for data (MSB first) and 8 for ACK, then wraps.
   function automatic logic [BIT_CNT_W-1:0] next_bit_idx(input logic [BIT_CNT_W-1:0] idx);
      return (idx == ACK_IDX) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/i2c_bus_conditioner_if.sv
// Raw I2C lines in, conditioned levels and single-cycle bus events out.
interface i2c_bus_conditioner_if;
   import i2c_la_pkg::*;

   logic                 scl_raw;
   logic                 sda_raw;
   logic                 scl_clean;
   logic                 sda_clean;
   logic                 scl_rise;
   logic                 scl_fall;
   logic                 start_det;
   logic                 stop_det;
   logic                 bus_busy;
   logic                 bit_valid;
   logic                 bit_data;
   logic [BIT_CNT_W-1:0] bit_idx;
   logic                 timeout;

   // master: drives the raw bus and consumes events; slave: the conditioner itself.
   modport master (
      output scl_raw, sda_raw,
      input  scl_clean, sda_clean, scl_rise, scl_fall, start_det, stop_det,
             bus_busy, bit_valid, bit_data, bit_idx, timeout
   );

   modport slave (
      input  scl_raw, sda_raw,
      output scl_clean, sda_clean, scl_rise, scl_fall, start_det, stop_det,
             bus_busy, bit_valid, bit_data, bit_idx, timeout
   );

endinterface

// File: rtl/i2c_glitch_filter.sv
// Synchroniser chain plus persistence counter for one asynchronous I2C line.
module i2c_glitch_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean
);

   localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_p;
   logic [CNT_W-1:0]       cnt;
   logic                   sync_out;

   assign sync_out = sync_p[SYNC_STAGES-1];

   // A new level is accepted only after FILT_LEN consecutive disagreeing cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p <= '1;
         cnt    <= '0;
         clean  <= 1'b1;
      end else begin
         sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
         if (sync_out == clean) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            clean <= sync_out;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// I2C bus conditioner: filtered levels, SCL edges, START/STOP, busy flag, bit samples.
// Optional bus timeout is compiled in with `define I2C_BUS_TIMEOUT_EN.
module i2c_bus_conditioner
   import i2c_la_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILT_LEN       = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic                 clk,
   input logic                 rst,
   i2c_bus_conditioner_if.slave bus
);

   logic scl_clean, sda_clean, scl_d, sda_d;
   logic scl_rise, scl_fall, sda_rise, sda_fall, scl_stable;
   logic start_det, stop_det, timeout, bit_valid;
   logic bit_data_q;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nxt, bit_idx_q;
   bus_state_e state, state_nxt;

   i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk(clk), .rst(rst), .raw(bus.scl_raw), .clean(scl_clean)
   );

   i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk(clk), .rst(rst), .raw(bus.sda_raw), .clean(sda_clean)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_d <= scl_clean;
         sda_d <= sda_clean;
      end
   end

   // Strobes are suppressed while rst is asserted so a reset edge never leaks an event.
   assign scl_rise   = !rst &&  scl_clean && !scl_d;
   assign scl_fall   = !rst && !scl_clean &&  scl_d;
   assign sda_rise   = !rst &&  sda_clean && !sda_d;
   assign sda_fall   = !rst && !sda_clean &&  sda_d;
   assign scl_stable = scl_clean && scl_d;
   assign start_det  = sda_fall && scl_stable;
   assign stop_det   = sda_rise && scl_stable;

`ifdef I2C_BUS_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (rst || state == IDLE || scl_rise || scl_fall || timeout) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout = !rst && state == BUSY && !scl_rise && !scl_fall &&
                    to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
`else
   // Timeout compiled out; the parameter stays so instantiations do not depend on the build.
   localparam logic TO_NEVER = (TIMEOUT_CYCLES < 0);
   assign timeout = TO_NEVER;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      bit_valid   = 1'b0;
      case (state)
         IDLE: begin
            bit_cnt_nxt = '0;
            if (start_det) state_nxt = BUSY;
         end
         BUSY: begin
            if (stop_det || timeout) begin
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
            end else if (start_det) begin
               bit_cnt_nxt = '0;
            end else if (scl_rise) begin
               bit_valid   = 1'b1;
               bit_cnt_nxt = next_bit_idx(bit_cnt);
            end
         end
         default: begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
         end
      endcase
   end

   // Sample is presented in the strobe cycle and held afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_data_q <= 1'b0;
         bit_idx_q  <= '0;
      end else if (bit_valid) begin
         bit_data_q <= sda_clean;
         bit_idx_q  <= bit_cnt;
      end
   end

   assign bus.scl_clean = scl_clean;
   assign bus.sda_clean = sda_clean;
   assign bus.scl_rise  = scl_rise;
   assign bus.scl_fall  = scl_fall;
   assign bus.start_det = start_det;
   assign bus.stop_det  = stop_det;
   assign bus.bus_busy  = (state == BUSY);
   assign bus.bit_valid = bit_valid;
   assign bus.bit_data  = bit_valid ? sda_clean : bit_data_q;
   assign bus.bit_idx   = bit_valid ? bit_cnt : bit_idx_q;
   assign bus.timeout   = timeout;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Scoreboard bench for i2c_bus_conditioner: protocol-level model predicts bus events.
module tb_i2c_bus_conditioner;
   import i2c_la_pkg::*;

   localparam int SYNC_STAGES    = 2;
   localparam int FILT_LEN       = 4;
   localparam int TIMEOUT_CYCLES = 50;

   localparam int EV_START = 0;
   localparam int EV_BIT   = 1;
   localparam int EV_STOP  = 2;
   localparam int EV_TO    = 3;

   typedef struct {
      int   kind;
      logic data;
      int   idx;
      logic busy;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   i2c_bus_conditioner_if bus();

   i2c_bus_conditioner #(
      .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   ev_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_rise = 0, exp_fall = 0, got_rise = 0, got_fall = 0;
   logic m_scl = 1'b1, m_sda = 1'b1, m_busy = 1'b0;
   int   m_cnt = 0;
   logic last_data = 1'b0;
   int   last_idx = 0;

   function automatic void push(int k, logic d, int i, logic b);
      ev_t e;
      e.kind = k; e.data = d; e.idx = i; e.busy = b;
      exp_q.push_back(e);
   endfunction

   // Bus rules applied to line-level transitions: SCL change wins, SDA change with SCL high is START/STOP.
   function automatic void model_step(logic scl, logic sda);
      if (scl != m_scl) begin
         if (scl) begin
            exp_rise++;
            if (m_busy) begin
               push(EV_BIT, sda, m_cnt, 1'b1);
               m_cnt = (m_cnt + 1) % 9;
            end
         end else begin
            exp_fall++;
         end
      end else if (sda != m_sda && scl) begin
         push(sda ? EV_STOP : EV_START, 1'b0, 0, m_busy);
         m_busy = !sda;
         m_cnt  = 0;
      end
      m_scl = scl;
      m_sda = sda;
   endfunction

   function automatic void check_event(int k);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event got kind=%0d busy=%0b data=%0b idx=%0d, expected no event",
                  k, bus.bus_busy, bus.bit_data, bus.bit_idx);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != k || bus.bus_busy !== e.busy ||
          (k == EV_BIT && (bus.bit_data !== e.data || bus.bit_idx !== 4'(e.idx)))) begin
         errors++;
         $display("FAIL event got kind=%0d busy=%0b data=%0b idx=%0d, expected kind=%0d busy=%0b data=%0b idx=%0d",
                  k, bus.bus_busy, bus.bit_data, bus.bit_idx, e.kind, e.busy, e.data, e.idx);
      end
      if (e.kind == EV_BIT) begin
         last_data = e.data;
         last_idx  = e.idx;
      end
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         last_data = 1'b0;
         last_idx  = 0;
      end else begin
         if (bus.scl_rise) got_rise++;
         if (bus.scl_fall) got_fall++;
         if (bus.start_det) check_event(EV_START);
         if (bus.bit_valid) check_event(EV_BIT);
         if (bus.stop_det)  check_event(EV_STOP);
         if (bus.timeout)   check_event(EV_TO);
         if (!bus.bit_valid) begin
            checks++;
            if (bus.bit_data !== last_data || bus.bit_idx !== 4'(last_idx)) begin
               errors++;
               $display("FAIL bit_hold got data=%0b idx=%0d, expected data=%0b idx=%0d",
                        bus.bit_data, bus.bit_idx, last_data, last_idx);
            end
         end
      end
   end

   task automatic drive(logic scl, logic sda, int hold);
      model_step(scl, sda);
      bus.scl_raw = scl;
      bus.sda_raw = sda;
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic set_lines(logic scl, logic sda);
      drive(scl, sda, $urandom_range(10, 6));
   endtask

   task automatic start_cond();
      if (!m_scl) begin
         set_lines(1'b0, 1'b1);
         set_lines(1'b1, 1'b1);
      end
      set_lines(1'b1, 1'b0);
      set_lines(1'b0, 1'b0);
   endtask

   task automatic send_bit(logic b);
      set_lines(1'b0, b);
      set_lines(1'b1, b);
      set_lines(1'b0, b);
   endtask

   task automatic send_byte(logic [7:0] d, logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(ack);
   endtask

   task automatic stop_cond();
      set_lines(1'b0, 1'b0);
      set_lines(1'b1, 1'b0);
      set_lines(1'b1, 1'b1);
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         @(posedge clk);
         w++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d events still pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_busy(string name);
      checks++;
      if (bus.bus_busy !== m_busy) begin
         errors++;
         $display("FAIL %s bus_busy got %0b expected %0b", name, bus.bus_busy, m_busy);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int lows;
      logic [7:0] b;
      bus.scl_raw = 1'b1;
      bus.sda_raw = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state: idle levels, no strobes, not busy.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.scl_clean, bus.sda_clean, bus.bus_busy, bus.scl_rise, bus.scl_fall,
              bus.start_det, bus.stop_det, bus.bit_valid, bus.timeout} !== 9'b110000000) begin
            errors++;
            $display("FAIL reset_idle cycle %0d got scl=%0b sda=%0b busy=%0b strobes=%0b, expected 1 1 0 0",
                     i, bus.scl_clean, bus.sda_clean, bus.bus_busy,
                     {bus.scl_rise, bus.scl_fall, bus.start_det, bus.stop_det, bus.bit_valid, bus.timeout});
         end
      end
      @(posedge clk); #1;

      // Short SDA pulses with SCL high must vanish in the filter.
      for (int g = 0; g < 6; g++) begin
         k = (g == 0) ? FILT_LEN - 1 : $urandom_range(FILT_LEN - 1, 1);
         bus.sda_raw = 1'b0;
         repeat (k) @(posedge clk);
         #1 bus.sda_raw = 1'b1;
         lows = 0;
         for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.sda_clean !== 1'b1) lows++;
         end
         checks++;
         if (lows != 0) begin
            errors++;
            $display("FAIL glitch len %0d got %0d cycles sda_clean low, expected 0", k, lows);
         end
         @(posedge clk); #1;
      end

      // START with latency measurement, byte 0xA5 + ACK 0, STOP.
      model_step(1'b1, 1'b0);
      bus.sda_raw = 1'b0;
      k = 0;
      do begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end while (bus.sda_clean !== 1'b0 && k < 20);
      checks++;
      if (k != SYNC_STAGES + FILT_LEN) begin
         errors++;
         $display("FAIL latency got %0d edges expected %0d", k, SYNC_STAGES + FILT_LEN);
      end
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1;
      set_lines(1'b0, 1'b0);
      send_byte(8'hA5, 1'b0);
      stop_cond();
      drain();
      check_busy("after_stop");

      // Repeated START after three bits.
      start_cond();
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1, 0)));
      start_cond();
      send_byte(8'($urandom), 1'b0);
      drain();
      check_busy("after_rep_start");
      stop_cond();
      drain();

      // SCL and SDA move together: only SCL edges.
      set_lines(1'b0, 1'b0);
      set_lines(1'b1, 1'b1);
      set_lines(1'b0, 1'b0);
      set_lines(1'b1, 1'b1);
      drain();

      // SCL held low after START: timeout build drops busy, default build stays busy.
      start_cond();
      model_step(1'b0, 1'b0);
`ifdef I2C_BUS_TIMEOUT_EN
      push(EV_TO, 1'b0, 0, 1'b1);
      m_busy = 1'b0;
      m_cnt  = 0;
`endif
      bus.scl_raw = 1'b0;
      repeat (TIMEOUT_CYCLES + 10) @(posedge clk);
      #1;
      check_busy("scl_low_hold");
      stop_cond();
      drain();

      // Reset in the middle of a byte, then a clean transaction.
      start_cond();
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(1, 0)));
      drain();
      rst = 1'b1;
      @(posedge clk); #1;
      bus.scl_raw = 1'b1;
      bus.sda_raw = 1'b1;
      m_scl = 1'b1; m_sda = 1'b1; m_busy = 1'b0; m_cnt = 0;
      repeat (6) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_busy("after_mid_reset");
      start_cond();
      send_byte(8'h3C, 1'b1);
      stop_cond();
      drain();

      // Randomized transactions.
      for (int t = 0; t < 12; t++) begin
         start_cond();
         for (int n = $urandom_range(3, 1); n > 0; n--) begin
            b = 8'($urandom);
            send_byte(b, 1'($urandom_range(1, 0)));
            if ($urandom_range(3, 0) == 0) begin
               for (int i = $urandom_range(8, 1); i > 0; i--) send_bit(1'($urandom_range(1, 0)));
               start_cond();
            end
         end
         stop_cond();
         if ($urandom_range(2, 0) == 0) begin
            set_lines(1'b0, 1'b0);
            set_lines(1'b1, 1'b1);
         end
      end
      drain();

      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (got_rise != exp_rise || got_fall != exp_fall) begin
         errors++;
         $display("FAIL scl_edges got rise=%0d fall=%0d expected rise=%0d fall=%0d",
                  got_rise, got_fall, exp_rise, exp_fall);
      end
      checks++;
      if (bus.scl_clean !== m_scl || bus.sda_clean !== m_sda || bus.bus_busy !== m_busy) begin
         errors++;
         $display("FAIL final_levels got scl=%0b sda=%0b busy=%0b expected scl=%0b sda=%0b busy=%0b",
                  bus.scl_clean, bus.sda_clean, bus.bus_busy, m_scl, m_sda, m_busy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
